// File: rtl/write_back_arbiter_if.sv
// rtl/write_back_arbiter_if.sv - execute/load request and register-file write bundle for write_back_arbiter
//
// Purpose: groups the execute request, the load-return request and the
// registered register-file write port into one bundle.
//   master : the execute/memory stages and the register file (drives requests, observes writes)
//   slave  : the arbiter (drives ready/write/occupancy, observes requests)
// Signals:
//   alu_valid/alu_ready/alu_dest/alu_data : execute result handshake
//   mem_valid/mem_ready/mem_dest/mem_data : load-return handshake into the load FIFO
//   write_address/write_data/write_enable : registered register-file write port
//   load_pending                          : load FIFO occupancy (0..2)
interface write_back_arbiter_if #(
    parameter int DATA_SIZE = 32,
    parameter int GPR_SIZE  = 5
);
    logic                 alu_valid;
    logic                 alu_ready;
    logic [GPR_SIZE-1:0]  alu_dest;
    logic [DATA_SIZE-1:0] alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [GPR_SIZE-1:0]  mem_dest;
    logic [DATA_SIZE-1:0] mem_data;
    logic [GPR_SIZE-1:0]  write_address;
    logic [DATA_SIZE-1:0] write_data;
    logic                 write_enable;
    logic [1:0]           load_pending;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready,
        input  write_address, write_data, write_enable, load_pending
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready,
        output write_address, write_data, write_enable, load_pending
    );
endinterface

// File: rtl/write_back_arbiter.sv
// rtl/write_back_arbiter.sv - round-robin arbiter for the register-file write port (ALU vs buffered loads)
//
// Purpose: shares the single register-file write port between execute results
// and load returns. Loads are buffered in a 2-entry FIFO; the ALU request and
// the FIFO head are arbitrated round-robin and the winner is registered onto
// the write port.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears FIFO, write port and arbitration history
//   bus   : write_back_arbiter_if.slave (requests in, ready/write/occupancy out)
module write_back_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int GPR_SIZE  = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    write_back_arbiter_if.slave   bus
);
    localparam int ENTRY_W = GPR_SIZE + DATA_SIZE;

    // FIFO is a 2-deep shift structure: slot0 is always the head.
    logic [1:0]           count_q, count_d;
    logic [ENTRY_W-1:0]   slot0_q, slot0_d;
    logic [ENTRY_W-1:0]   slot1_q, slot1_d;
    // 1 = ALU was granted most recently, 0 = FIFO head was.
    logic                 last_alu_q, last_alu_d;
    logic                 write_enable_q, write_enable_d;
    logic [GPR_SIZE-1:0]  write_address_q, write_address_d;
    logic [DATA_SIZE-1:0] write_data_q, write_data_d;

    logic                 req_alu, req_mem;
    logic                 grant_alu, grant_mem;
    logic                 mem_ready, push;
    logic [ENTRY_W-1:0]   push_entry;
    logic [GPR_SIZE-1:0]  win_dest;
    logic [DATA_SIZE-1:0] win_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q         <= 2'd0;
            slot0_q         <= '0;
            slot1_q         <= '0;
            last_alu_q      <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            count_q         <= count_d;
            slot0_q         <= slot0_d;
            slot1_q         <= slot1_d;
            last_alu_q      <= last_alu_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
        end
    end

    // Arbitration: FIFO eligibility comes from registered count only, so a
    // load pushed this cycle cannot be granted until the next one.
    always_comb begin
        req_alu   = bus.alu_valid;
        req_mem   = (count_q != 2'd0);
        grant_alu = req_alu && (!req_mem || !last_alu_q);
        grant_mem = req_mem && (!req_alu || last_alu_q);

        last_alu_d = last_alu_q;
        if (grant_alu) begin
            last_alu_d = 1'b1;
        end else if (grant_mem) begin
            last_alu_d = 1'b0;
        end
    end

    always_comb begin
        mem_ready  = (count_q != 2'd2);
        push       = bus.mem_valid && mem_ready;
        push_entry = {bus.mem_dest, bus.mem_data};

        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({push, grant_mem})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = push_entry;
                end else begin
                    slot1_d = push_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push needs count < 2 and pop needs count > 0, so count is 1:
                // the new entry simply replaces the departing head.
                slot0_d = push_entry;
            end
            default: begin
            end
        endcase
    end

    // Write port: register-0 writes still complete the handshake but are
    // squashed to an all-zero idle write.
    always_comb begin
        win_dest = grant_alu ? bus.alu_dest : slot0_q[ENTRY_W-1:DATA_SIZE];
        win_data = grant_alu ? bus.alu_data : slot0_q[DATA_SIZE-1:0];

        write_enable_d  = 1'b0;
        write_address_d = '0;
        write_data_d    = '0;
        if ((grant_alu || grant_mem) && (win_dest != '0)) begin
            write_enable_d  = 1'b1;
            write_address_d = win_dest;
            write_data_d    = win_data;
        end
    end

    assign bus.alu_ready     = grant_alu;
    assign bus.mem_ready     = mem_ready;
    assign bus.write_enable  = write_enable_q;
    assign bus.write_address = write_address_q;
    assign bus.write_data    = write_data_q;
    assign bus.load_pending  = count_q;
endmodule
